// File: rtl/cordic_update_stage.sv
// One registered rotation-mode CORDIC micro-rotation: steers currentAngle toward wantedAngle.
// Define CORDIC_UPDATE_SAT_EN to saturate nx/ny on signed overflow; by default they wrap.
module cordic_update_stage #(
    parameter int WIDTH   = 32,
    parameter int FPSHIFT = 28
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [WIDTH-1:0] wantedAngle,
    input  logic        [4:0]       iterate,
    input  logic signed [WIDTH-1:0] x,
    input  logic signed [WIDTH-1:0] y,
    input  logic signed [WIDTH-1:0] currentAngle,
    input  logic signed [WIDTH-1:0] atan,
    output logic signed [WIDTH-1:0] nangle,
    output logic signed [WIDTH-1:0] nx,
    output logic signed [WIDTH-1:0] ny
);

    // FPSHIFT only documents the number format; reject nonsensical values early.
    if (FPSHIFT < 0 || FPSHIFT >= WIDTH) begin : g_bad_fpshift
        $error("cordic_update_stage: FPSHIFT must lie in [0, WIDTH-1]");
    end

    logic                    w_dir_pos;
    logic                    w_shift_big;
    logic signed [WIDTH-1:0] w_x_sh;
    logic signed [WIDTH-1:0] w_y_sh;
    logic signed [WIDTH-1:0] w_nangle;
    logic signed [WIDTH-1:0] w_a   [2];
    logic signed [WIDTH-1:0] w_b   [2];
    logic                    w_add [2];
    logic signed [WIDTH-1:0] w_res [2];

    logic signed [WIDTH-1:0] r_nx;
    logic signed [WIDTH-1:0] r_ny;
    logic signed [WIDTH-1:0] r_nangle;

    // Equal angles rotate clockwise (d = -1).
    assign w_dir_pos   = currentAngle < wantedAngle;
    assign w_shift_big = int'(iterate) >= WIDTH;

    always_comb begin
        w_x_sh = x >>> iterate;
        w_y_sh = y >>> iterate;
        if (w_shift_big) begin
            w_x_sh = {WIDTH{x[WIDTH-1]}};
            w_y_sh = {WIDTH{y[WIDTH-1]}};
        end
    end

    // Lane 0 is x (adds y>>>i when d=+1), lane 1 is y (adds x>>>i when d=-1).
    assign w_a[0]   = x;
    assign w_b[0]   = w_y_sh;
    assign w_add[0] = w_dir_pos;
    assign w_a[1]   = y;
    assign w_b[1]   = w_x_sh;
    assign w_add[1] = !w_dir_pos;

    for (genvar gi = 0; gi < 2; gi++) begin : g_lane
`ifdef CORDIC_UPDATE_SAT_EN
        localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
        localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};
        logic [WIDTH:0] w_ext;
        assign w_ext = w_add[gi]
                     ? ({w_a[gi][WIDTH-1], w_a[gi]} + {w_b[gi][WIDTH-1], w_b[gi]})
                     : ({w_a[gi][WIDTH-1], w_a[gi]} - {w_b[gi][WIDTH-1], w_b[gi]});
        // Disagreeing top two bits of the extended result mean signed overflow.
        assign w_res[gi] = (w_ext[WIDTH] != w_ext[WIDTH-1])
                         ? (w_ext[WIDTH] ? SMIN : SMAX)
                         : w_ext[WIDTH-1:0];
`else
        assign w_res[gi] = w_add[gi] ? (w_a[gi] + w_b[gi]) : (w_a[gi] - w_b[gi]);
`endif
    end

    assign w_nangle = w_dir_pos ? (currentAngle + atan) : (currentAngle - atan);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nx     <= '0;
            r_ny     <= '0;
            r_nangle <= '0;
        end else begin
            r_nx     <= w_res[0];
            r_ny     <= w_res[1];
            r_nangle <= w_nangle;
        end
    end

    assign nx     = r_nx;
    assign ny     = r_ny;
    assign nangle = r_nangle;

endmodule

// File: tb/tb_cordic_update_stage.sv
// Scoreboard bench for cordic_update_stage: directed rows, async reset, random traffic.
// Build with CORDIC_UPDATE_SAT_EN defined to check the saturating variant.
module tb_cordic_update_stage;

`ifdef CORDIC_UPDATE_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] nx;
        logic [31:0] ny;
        logic [31:0] na;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] wantedAngle, x, y, currentAngle, atan;
    logic [4:0]  iterate;
    logic [31:0] nangle, nx, ny;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   txn    = 0;

    cordic_update_stage #(.WIDTH(32), .FPSHIFT(28)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wantedAngle  (wantedAngle),
        .iterate      (iterate),
        .x            (x),
        .y            (y),
        .currentAngle (currentAngle),
        .atan         (atan),
        .nangle       (nangle),
        .nx           (nx),
        .ny           (ny)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Arithmetic right shift as floor division by 2^sh.
    function automatic longint asr(input longint v, input int sh);
        longint p, q;
        if (sh >= 32) return (v < 0) ? -64'sd1 : 64'sd0;
        p = 64'sd1 <<< sh;
        q = v / p;
        if (v < 0 && q * p != v) q = q - 1;
        return q;
    endfunction

    function automatic logic [31:0] fit(input longint v, input bit sat);
        if (sat && v > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (sat && v < -64'sd2147483648) return 32'h8000_0000;
        return v[31:0];
    endfunction

    function automatic exp_t model(input logic [31:0] mx, input logic [31:0] my,
                                   input logic [31:0] mc, input logic [31:0] mw,
                                   input logic [31:0] ma, input int mi);
        exp_t   e;
        longint sx, sy, sc, sw, sa, d;
        sx = longint'($signed(mx));
        sy = longint'($signed(my));
        sc = longint'($signed(mc));
        sw = longint'($signed(mw));
        sa = longint'($signed(ma));
        d  = (sc < sw) ? 64'sd1 : -64'sd1;
        e.nx = fit(sx + d * asr(sy, mi), SAT);
        e.ny = fit(sy - d * asr(sx, mi), SAT);
        e.na = fit(sc + d * sa, 1'b0);
        return e;
    endfunction

    task automatic drive(input logic [31:0] dx, input logic [31:0] dy, input logic [31:0] dc,
                         input logic [31:0] dw, input logic [31:0] da, input logic [4:0] di,
                         input exp_t e);
        @(negedge clk);
        x = dx; y = dy; currentAngle = dc; wantedAngle = dw; atan = da; iterate = di;
        sb_q.push_back(e);
    endtask

    task automatic drive_rand();
        logic [31:0] rx, ry, rc, rw, ra;
        logic [4:0]  ri;
        rx = $urandom;
        ry = $urandom;
        rc = $urandom;
        rw = ($urandom_range(0, 7) == 0) ? rc : $urandom;
        ra = $urandom;
        ri = 5'($urandom_range(0, 31));
        if ($urandom_range(0, 3) == 0) begin
            rx = 32'h7FFF_FFFF - 32'($urandom_range(0, 255));
            ry = ($urandom_range(0, 1) == 1) ? 32'h8000_0000 + 32'($urandom_range(0, 255)) : rx;
            ri = 5'($urandom_range(0, 2));
        end
        drive(rx, ry, rc, rw, ra, ri, model(rx, ry, rc, rw, ra, int'(ri)));
    endtask

    function automatic exp_t mk(input logic [31:0] ex, input logic [31:0] ey, input logic [31:0] ea);
        exp_t e;
        e.nx = ex; e.ny = ey; e.na = ea;
        return e;
    endfunction

    // Monitor: every cycle with an outstanding expectation, one result is compared.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                txn++;
                $display("txn %0d: nx=0x%08h ny=0x%08h nangle=0x%08h", txn, nx, ny, nangle);
                chk("nx", nx, e.nx);
                chk("ny", ny, e.ny);
                chk("nangle", nangle, e.na);
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && sb_q.size() != 0; k++) begin
            @(posedge clk);
            #2;
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results outstanding, expected 0", sb_q.size());
        end
    endtask

    initial begin
        x = '0; y = '0; currentAngle = '0; wantedAngle = '0; atan = '0; iterate = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        chk("reset_nx", nx, 32'h0);
        chk("reset_ny", ny, 32'h0);
        chk("reset_nangle", nangle, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        drive(32'h0, 32'h09B74EDA, 32'h0, 32'h08000000, 32'h0C90FDAA, 5'd0,
              mk(32'h09B74EDA, 32'h09B74EDA, 32'h0C90FDAA));
        drive(32'h09B74EDA, 32'h09B74EDA, 32'h0C90FDAA, 32'h08000000, 32'h076B19C1, 5'd1,
              mk(32'h04DBA76D, 32'h0E92F647, 32'h0525E3E9));
        drive(32'h10000000, 32'h0, 32'h04000000, 32'h04000000, 32'h03EB6EBF, 5'd2,
              mk(32'h10000000, 32'h04000000, 32'h00149141));
        drive(32'hFFFFFFFF, 32'h0, 32'h0, 32'h1, 32'h0, 5'd4,
              mk(32'hFFFFFFFF, 32'h00000001, 32'h0));
        drive(32'h7FFFFFF0, 32'h7FFFFFF0, 32'h0, 32'h1, 32'h1, 5'd0,
              mk(SAT ? 32'h7FFFFFFF : 32'hFFFFFFE0, 32'h0, 32'h1));
        drive(32'h0, 32'h09B74EDA, 32'h0, 32'h08000000, 32'h0C90FDAA, 5'd0,
              mk(32'h09B74EDA, 32'h09B74EDA, 32'h0C90FDAA));
        drain();

        // Asynchronous reset mid-cycle with nonzero inputs still applied.
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_nx", nx, 32'h0);
        chk("async_ny", ny, 32'h0);
        chk("async_nangle", nangle, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("held_nx", nx, 32'h0);
        chk("held_ny", ny, 32'h0);
        chk("held_nangle", nangle, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        x = 32'h0; y = 32'h09B74EDA; currentAngle = 32'h0; wantedAngle = 32'h08000000;
        atan = 32'h0C90FDAA; iterate = 5'd0;
        sb_q.push_back(mk(32'h09B74EDA, 32'h09B74EDA, 32'h0C90FDAA));
        drain();

        for (int n = 0; n < 300; n++) drive_rand();
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
